color_manager_timing_gen: RTL and testbench

Programmable raster timing generator for the Color Manager. It produces the line-level sync (HSync) that drives the Sync input of the color manager pixel counter, plus frame-level sync (VSync), beam position counters and line/frame start strobes. Timing configuration is double-buffered and takes effect only on frame boundaries, so register writes never tear a frame.

---
 rtl/color_manager_timing_gen.sv | 136 +++++++++++++
 tb/tb_color_manager_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/color_manager_timing_gen.sv
// Raster timing generator: line/frame sync, beam counters and start strobes.
// Config is shadowed and reloaded only on frame boundaries.
module color_manager_timing_gen #(
  parameter int unsigned H_WIDTH = 11,
  parameter int unsigned V_WIDTH = 10
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Enable,
  input  logic [H_WIDTH-1:0] HSyncLen,
  input  logic [H_WIDTH-1:0] HTotal,
  input  logic [V_WIDTH-1:0] VSyncLen,
  input  logic [V_WIDTH-1:0] VTotal,
  output logic               HSync,
  output logic               VSync,
  output logic [H_WIDTH-1:0] HCount,
  output logic [V_WIDTH-1:0] VCount,
  output logic               LineStart,
  output logic               FrameStart,
  output logic               ConfigError
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [H_WIDTH-1:0] hsl_sh, ht_sh, hsl_n, ht_n, hcount_n;
  logic [V_WIDTH-1:0] vsl_sh, vt_sh, vsl_n, vt_n, vcount_n;
  logic               err_n;
  logic               hsync_n, vsync_n, line_start_n, frame_start_n;
  logic               cfg_valid, line_end, frame_end, load, run_n;

  assign cfg_valid = (HTotal >= H_WIDTH'(2)) && (HSyncLen < HTotal) &&
                     (VTotal >= V_WIDTH'(1)) && (VSyncLen < VTotal);
  assign line_end  = (HCount == ht_sh - H_WIDTH'(1));
  assign frame_end = line_end && (VCount == vt_sh - V_WIDTH'(1));

  always_comb begin
    state_n  = state;
    hcount_n = HCount;
    vcount_n = VCount;
    err_n    = ConfigError;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        hcount_n = '0;
        vcount_n = '0;
        if (Enable) begin
          if (cfg_valid) begin
            state_n = RUN;
            load    = 1'b1;
            err_n   = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        // Enable drop outranks the frame-wrap reload and its error check
        if (!Enable) begin
          state_n  = IDLE;
          hcount_n = '0;
          vcount_n = '0;
        end else if (frame_end) begin
          hcount_n = '0;
          vcount_n = '0;
          if (cfg_valid) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end else if (line_end) begin
          hcount_n = '0;
          vcount_n = VCount + V_WIDTH'(1);
        end else begin
          hcount_n = HCount + H_WIDTH'(1);
        end
      end
    endcase
  end

  always_comb begin
    hsl_n = hsl_sh;
    ht_n  = ht_sh;
    vsl_n = vsl_sh;
    vt_n  = vt_sh;
    if (load) begin
      hsl_n = HSyncLen;
      ht_n  = HTotal;
      vsl_n = VSyncLen;
      vt_n  = VTotal;
    end
  end

  // Outputs are derived from next-cycle counters and shadows so they register
  // in step with HCount/VCount.
  always_comb begin
    run_n         = (state_n == RUN);
    hsync_n       = run_n && (hcount_n >= hsl_n);
    vsync_n       = run_n && (vcount_n >= vsl_n);
    line_start_n  = run_n && (hcount_n == '0);
    frame_start_n = line_start_n && (vcount_n == '0);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      hsl_sh      <= '0;
      ht_sh       <= '0;
      vsl_sh      <= '0;
      vt_sh       <= '0;
      HCount      <= '0;
      VCount      <= '0;
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      LineStart   <= 1'b0;
      FrameStart  <= 1'b0;
      ConfigError <= 1'b0;
    end else begin
      state       <= state_n;
      hsl_sh      <= hsl_n;
      ht_sh       <= ht_n;
      vsl_sh      <= vsl_n;
      vt_sh       <= vt_n;
      HCount      <= hcount_n;
      VCount      <= vcount_n;
      HSync       <= hsync_n;
      VSync       <= vsync_n;
      LineStart   <= line_start_n;
      FrameStart  <= frame_start_n;
      ConfigError <= err_n;
    end
  end

endmodule

// File: tb/tb_color_manager_timing_gen.sv
// Scoreboard bench for color_manager_timing_gen: a frame-position model
// predicts every registered output; a monitor compares each cycle.
module tb_color_manager_timing_gen;
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Enable = 1'b0;
  logic [HW-1:0] HSyncLen = '0;
  logic [HW-1:0] HTotal = '0;
  logic [VW-1:0] VSyncLen = '0;
  logic [VW-1:0] VTotal = '0;
  logic          HSync, VSync, LineStart, FrameStart, ConfigError;
  logic [HW-1:0] HCount;
  logic [VW-1:0] VCount;

  color_manager_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable),
    .HSyncLen(HSyncLen), .HTotal(HTotal), .VSyncLen(VSyncLen), .VTotal(VTotal),
    .HSync(HSync), .VSync(VSync), .HCount(HCount), .VCount(VCount),
    .LineStart(LineStart), .FrameStart(FrameStart), .ConfigError(ConfigError)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int hc;
    int vc;
    bit hs, vs, ls, fs, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Stimulus settings applied at the next step
  int cfg_ht, cfg_hsl, cfg_vt, cfg_vsl;
  bit cfg_en, cfg_rst;

  // Model: running flag plus a linear cycle index within the current frame
  bit m_run, m_err;
  int m_p, m_ht, m_hsl, m_vt, m_vsl;

  function automatic bit cfg_ok();
    return (cfg_ht >= 2) && (cfg_hsl < cfg_ht) && (cfg_vt >= 1) && (cfg_vsl < cfg_vt);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic load_shadow();
    m_ht = cfg_ht; m_hsl = cfg_hsl; m_vt = cfg_vt; m_vsl = cfg_vsl;
  endtask

  task automatic model_edge();
    exp_t e;
    if (cfg_rst) begin
      m_run = 0; m_err = 0; m_p = 0;
      m_ht = 0; m_hsl = 0; m_vt = 0; m_vsl = 0;
    end else if (!m_run) begin
      if (cfg_en) begin
        if (cfg_ok()) begin
          load_shadow(); m_run = 1; m_p = 0; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (!cfg_en) begin
      m_run = 0;
    end else if (m_p == m_ht * m_vt - 1) begin
      if (cfg_ok()) begin
        load_shadow(); m_p = 0;
      end else begin
        m_run = 0; m_err = 1;
      end
    end else begin
      m_p++;
    end
    e.hc  = m_run ? m_p % m_ht : 0;
    e.vc  = m_run ? m_p / m_ht : 0;
    e.hs  = m_run && (e.hc >= m_hsl);
    e.vs  = m_run && (e.vc >= m_vsl);
    e.ls  = m_run && (e.hc == 0);
    e.fs  = e.ls && (e.vc == 0);
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge Clk);
    Rst      = cfg_rst;
    Enable   = cfg_en;
    HTotal   = HW'(cfg_ht);
    HSyncLen = HW'(cfg_hsl);
    VTotal   = VW'(cfg_vt);
    VSyncLen = VW'(cfg_vsl);
    model_edge();
  endtask

  task automatic set_cfg(input int ht, input int hsl, input int vt, input int vsl);
    cfg_ht = ht; cfg_hsl = hsl; cfg_vt = vt; cfg_vsl = vsl;
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("HCount", int'(HCount), e.hc);
        check("VCount", int'(VCount), e.vc);
        check("HSync", int'(HSync), int'(e.hs));
        check("VSync", int'(VSync), int'(e.vs));
        check("LineStart", int'(LineStart), int'(e.ls));
        check("FrameStart", int'(FrameStart), int'(e.fs));
        check("ConfigError", int'(ConfigError), int'(e.err));
      end
    end
  end

  initial begin
    int guard;
    cfg_rst = 1; cfg_en = 0;
    set_cfg(0, 0, 0, 0);
    m_run = 0; m_err = 0; m_p = 0;
    m_ht = 0; m_hsl = 0; m_vt = 0; m_vsl = 0;
    repeat (3) step();

    // Basic 8x4 raster
    cfg_rst = 0; cfg_en = 1;
    set_cfg(8, 2, 4, 1);
    repeat (70) step();

    // Mid-frame HTotal change only lands after the frame wrap
    guard = 0;
    while (!(m_run && (m_p / m_ht) == 2) && guard < 100) begin step(); guard++; end
    check("reach_vcount2", guard < 100, 1);
    cfg_ht = 10;
    repeat (80) step();

    // Enable drop on the wrap edge with an invalid config pending
    guard = 0;
    while (!(m_run && m_p == m_ht * m_vt - 1) && guard < 100) begin step(); guard++; end
    check("reach_wrap", guard < 100, 1);
    cfg_en = 0; cfg_hsl = cfg_ht;
    repeat (3) step();

    // Invalid start, then corrected config
    set_cfg(4, 4, 4, 1);
    cfg_en = 1;
    repeat (3) step();
    cfg_hsl = 1;
    repeat (20) step();

    // Config made invalid mid-run is rejected at the wrap
    cfg_vsl = 4;
    repeat (40) step();

    // Minimal raster
    cfg_en = 0;
    step();
    set_cfg(2, 0, 1, 0);
    cfg_en = 1;
    repeat (12) step();

    // Async reset mid-line at HCount=5, VCount=2
    set_cfg(8, 2, 4, 1);
    guard = 0;
    while (!(m_run && m_ht == 8 && (m_p % m_ht) == 5 && (m_p / m_ht) == 2) && guard < 200) begin
      step(); guard++;
    end
    check("reach_hc5_vc2", guard < 200, 1);
    cfg_rst = 1;
    step();
    #1;
    check("async_HSync", int'(HSync), 0);
    check("async_VSync", int'(VSync), 0);
    check("async_HCount", int'(HCount), 0);
    check("async_VCount", int'(VCount), 0);
    check("async_LineStart", int'(LineStart), 0);
    check("async_FrameStart", int'(FrameStart), 0);
    step();
    cfg_rst = 0;
    repeat (40) step();

    // Randomized configs, enable toggles and mid-frame writes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(149, 0) == 0)
        set_cfg(int'($urandom_range(12, 0)), int'($urandom_range(12, 0)),
                int'($urandom_range(5, 0)), int'($urandom_range(5, 0)));
      if ($urandom_range(119, 0) == 0) cfg_en = ~cfg_en;
      step();
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge Clk); guard++; end
    #2;
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
